// File: rtl/connect_plotter_pipe_if.sv
// Pixel-stream and board-state bundle between the VGA timing generator and the
// connect-game plotter; the plotter's RGB result travels back on the same bundle.
interface connect_plotter_pipe_if #(
  parameter int COLS = 7,
  parameter int ROWS = 6
);
  logic [9:0]             pixel_col;
  logic [9:0]             pixel_row;
  logic                   pixel_valid;
  logic                   frame_start;
  logic [COLS*ROWS*2-1:0] panel;
  logic [COLS-1:0]        play;
  logic                   turn;
  logic                   win;
  logic [2:0]             winner_column;
  logic [2:0]             winner_row;
  logic [1:0]             winner_kind;
  logic                   full;
  logic                   rgb_valid;
  logic [3:0]             data_red;
  logic [3:0]             data_green;
  logic [3:0]             data_blue;

  modport master (
    output pixel_col, pixel_row, pixel_valid, frame_start, panel, play, turn,
           win, winner_column, winner_row, winner_kind, full,
    input  rgb_valid, data_red, data_green, data_blue
  );

  modport slave (
    input  pixel_col, pixel_row, pixel_valid, frame_start, panel, play, turn,
           win, winner_column, winner_row, winner_kind, full,
    output rgb_valid, data_red, data_green, data_blue
  );
endinterface

// File: rtl/connect_plotter_pipe.sv
// Two-stage pixel colouriser for an N x M connect game: stage 1 decodes which cell
// or selector box the coordinate hits, stage 2 turns that into 12-bit RGB.
module connect_plotter_pipe #(
  parameter int COLS         = 7,
  parameter int ROWS         = 6,
  parameter int WIN_LEN      = 4,
  parameter int H_RES        = 640,
  parameter int V_RES        = 480,
  parameter int CELL         = 40,
  parameter int GAP          = 30,
  parameter int MARGIN_X     = 90,
  parameter int MARGIN_TOP   = 20,
  parameter int BAR_GAP      = 20,
  parameter int BAR_H        = 20,
  parameter int BLINK_FRAMES = 30
) (
  input logic clk,
  input logic rst,
  connect_plotter_pipe_if.slave bus
);

  localparam int P  = CELL + GAP;
  localparam int BY = MARGIN_TOP + ROWS*CELL + (ROWS-1)*GAP + BAR_GAP;
  localparam int NB = COLS*ROWS*2;
  localparam int CW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  logic [NB-1:0]   snap_panel;
  logic [COLS-1:0] snap_play;
  logic            snap_turn;
  logic            snap_win;
  logic [2:0]      snap_wc;
  logic [2:0]      snap_wr;
  logic [1:0]      snap_wk;
  logic            snap_full;

  logic [CW-1:0]   blink_cnt;
  logic            blink_phase;

  int              px, py;
  logic            x_hit, y_hit, bar_y;
  logic [2:0]      x_idx, y_idx;

  logic            s1_valid, s1_cell, s1_bar;
  logic [9:0]      s1_col, s1_row;
  logic [2:0]      s1_i, s1_j, s1_bi;

  int              piece_idx, dc, dr;
  logic [1:0]      piece;
  logic            in_win, box_lit;
  logic signed [4:0] cc, rr;
  logic [11:0]     rgb_n, rgb_q;
  logic            rgb_valid_q;

  // Board state is frozen at frame_start so a whole frame is drawn from one picture.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      snap_panel <= '0;
      snap_play  <= '0;
      snap_turn  <= 1'b0;
      snap_win   <= 1'b0;
      snap_wc    <= '0;
      snap_wr    <= '0;
      snap_wk    <= '0;
      snap_full  <= 1'b0;
    end else if (bus.frame_start) begin
      snap_panel <= bus.panel;
      snap_play  <= bus.play;
      snap_turn  <= bus.turn;
      snap_win   <= bus.win;
      snap_wc    <= bus.winner_column;
      snap_wr    <= bus.winner_row;
      snap_wk    <= bus.winner_kind;
      snap_full  <= bus.full;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      blink_cnt   <= '0;
      blink_phase <= 1'b0;
    end else if (bus.frame_start) begin
      if (!bus.win) begin
        blink_cnt   <= '0;
        blink_phase <= 1'b0;
      end else if (blink_cnt == CW'(BLINK_FRAMES-1)) begin
        blink_cnt   <= '0;
        blink_phase <= ~blink_phase;
      end else begin
        blink_cnt <= blink_cnt + CW'(1);
      end
    end
  end

  always_comb begin
    px    = {22'd0, bus.pixel_col};
    py    = {22'd0, bus.pixel_row};
    x_hit = 1'b0;
    x_idx = '0;
    y_hit = 1'b0;
    y_idx = '0;
    for (int i = 0; i < COLS; i++) begin
      if (px >= MARGIN_X + i*P && px < MARGIN_X + i*P + CELL) begin
        x_hit = 1'b1;
        x_idx = 3'(i);
      end
    end
    for (int j = 0; j < ROWS; j++) begin
      if (py >= MARGIN_TOP + j*P && py < MARGIN_TOP + j*P + CELL) begin
        y_hit = 1'b1;
        y_idx = 3'(j);
      end
    end
    bar_y = (py >= BY) && (py < BY + BAR_H);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_col   <= '0;
      s1_row   <= '0;
      s1_cell  <= 1'b0;
      s1_i     <= '0;
      s1_j     <= '0;
      s1_bar   <= 1'b0;
      s1_bi    <= '0;
    end else begin
      s1_valid <= bus.pixel_valid;
      s1_col   <= bus.pixel_col;
      s1_row   <= bus.pixel_row;
      s1_cell  <= bus.pixel_valid && x_hit && y_hit;
      s1_i     <= x_idx;
      s1_j     <= y_idx;
      s1_bar   <= bus.pixel_valid && x_hit && bar_y;
      s1_bi    <= x_idx;
    end
  end

  // Signed 5-bit stepping keeps r-k below zero from aliasing onto a real row.
  always_comb begin
    rgb_n     = 12'h000;
    in_win    = 1'b0;
    box_lit   = 1'b0;
    cc        = '0;
    rr        = '0;
    piece_idx = 2*(int'(s1_i)*ROWS + int'(s1_j));
    piece     = (piece_idx < NB) ? snap_panel[piece_idx +: 2] : 2'b00;
    dc        = (snap_wk == 2'b01) ? 0 : 1;
    dr        = (snap_wk == 2'b00) ? 0 : ((snap_wk == 2'b11) ? -1 : 1);
    for (int k = 0; k < WIN_LEN; k++) begin
      cc = 5'(int'(snap_wc) + k*dc);
      rr = 5'(int'(snap_wr) + k*dr);
      if (cc == {2'b00, s1_i} && rr == {2'b00, s1_j}) in_win = 1'b1;
    end
    for (int i = 0; i < COLS; i++) begin
      if (s1_bi == 3'(i) && snap_play[i]) box_lit = 1'b1;
    end
    if (s1_valid && ({22'd0, s1_col} < H_RES) && ({22'd0, s1_row} < V_RES)) begin
      if (s1_cell) begin
        if (snap_win && !blink_phase && in_win)
          rgb_n = snap_turn ? 12'hA0A : 12'h0AA;
        else if (piece == 2'b01)
          rgb_n = 12'hF00;
        else if (piece == 2'b10)
          rgb_n = 12'h0F0;
      end else if (s1_bar) begin
        if (snap_win)
          rgb_n = snap_turn ? 12'hF00 : 12'h0F0;
        else if (snap_full)
          rgb_n = 12'h00F;
        else if (box_lit)
          rgb_n = snap_turn ? 12'h0F0 : 12'hF00;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rgb_q       <= '0;
      rgb_valid_q <= 1'b0;
    end else begin
      rgb_q       <= rgb_n;
      rgb_valid_q <= s1_valid;
    end
  end

  assign bus.rgb_valid  = rgb_valid_q;
  assign bus.data_red   = rgb_q[11:8];
  assign bus.data_green = rgb_q[7:4];
  assign bus.data_blue  = rgb_q[3:0];

endmodule
